// File: rtl/approx_resp_checker.sv
// Accumulates exact-vs-approx quality metrics over one exhaustive partition sweep.
// Optional APPROX_CHK_MED_EN adds the ed_sum (mean error distance) accumulator.
module approx_resp_checker #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_vec,
  input  logic [OUT_W-1:0]                 exact,
  input  logic [OUT_W-1:0]                 approx,
  output logic                             busy,
  output logic                             done,
  output logic [IN_W:0]                    err_count,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]  hd_sum,
  output logic [OUT_W-1:0]                 max_ed,
  output logic                             seq_err,
`ifdef APPROX_CHK_MED_EN
  output logic [IN_W+OUT_W-1:0]            ed_sum,
`endif
  output logic [IN_W-1:0]                  first_err
);

  localparam int HDW = $clog2(OUT_W+1);
  localparam int HSW = IN_W + HDW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic              w_acc;
  logic              w_last;
  logic              w_clr;
  logic [OUT_W-1:0]  w_x;
  logic [HDW-1:0]    w_hd;
  logic [OUT_W:0]    w_diff;
  logic [OUT_W-1:0]  w_ed;

  logic [IN_W-1:0]   r_idx;
  logic              r_s1_v;
  logic              r_s1_mis;
  logic [HDW-1:0]    r_s1_hd;
  logic [OUT_W-1:0]  r_s1_ed;
  logic [IN_W-1:0]   r_s1_vec;
  logic              r_first_seen;
  logic [IN_W:0]     r_err;
  logic [HSW-1:0]    r_hd;
  logic [OUT_W-1:0]  r_max;
  logic              r_seq;
  logic [IN_W-1:0]   r_first;
`ifdef APPROX_CHK_MED_EN
  logic [IN_W+OUT_W-1:0] r_eds;
`endif

  assign in_ready = (r_state == RUN);
  assign busy     = (r_state == RUN) || (r_state == DRAIN);
  assign done     = (r_state == DONE);
  assign w_acc    = in_valid && in_ready;
  assign w_last   = (r_idx == {IN_W{1'b1}});
  assign w_clr    = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_nxt = RUN;
      RUN:     if (w_acc && w_last) w_nxt = DRAIN;
      DRAIN:   w_nxt = DONE;
      DONE:    if (start) w_nxt = RUN;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_x = exact ^ approx;

  always_comb begin
    w_hd = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_hd = w_hd + HDW'(w_x[i]);
    end
  end

  // Borrow bit of the widened difference selects the magnitude direction.
  assign w_diff = {1'b0, exact} - {1'b0, approx};
  assign w_ed   = w_diff[OUT_W] ? (approx - exact) : w_diff[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_idx        <= '0;
      r_s1_v       <= 1'b0;
      r_s1_mis     <= 1'b0;
      r_s1_hd      <= '0;
      r_s1_ed      <= '0;
      r_s1_vec     <= '0;
      r_first_seen <= 1'b0;
      r_err        <= '0;
      r_hd         <= '0;
      r_max        <= '0;
      r_seq        <= 1'b0;
      r_first      <= '0;
`ifdef APPROX_CHK_MED_EN
      r_eds        <= '0;
`endif
    end else begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_idx    <= r_idx + 1'b1;
        r_s1_mis <= |w_x;
        r_s1_hd  <= w_hd;
        r_s1_ed  <= w_ed;
        r_s1_vec <= in_vec;
        if (in_vec != r_idx) r_seq <= 1'b1;
      end
      if (r_s1_v) begin
        r_err <= r_err + (IN_W+1)'(r_s1_mis);
        r_hd  <= r_hd + HSW'(r_s1_hd);
        if (r_s1_ed > r_max) r_max <= r_s1_ed;
        if (r_s1_mis && !r_first_seen) begin
          r_first_seen <= 1'b1;
          r_first      <= r_s1_vec;
        end
`ifdef APPROX_CHK_MED_EN
        r_eds <= r_eds + (IN_W+OUT_W)'(r_s1_ed);
`endif
      end
    end
  end

  assign err_count = r_err;
  assign hd_sum    = r_hd;
  assign max_ed    = r_max;
  assign seq_err   = r_seq;
  assign first_err = r_first;
`ifdef APPROX_CHK_MED_EN
  assign ed_sum    = r_eds;
`endif

endmodule
